// File: rtl/psum_acc_seq_pkg.sv
// Shared types and constants for the accumulation-phase sequencer and its address generator.
// Also carries the inst bit positions so the sequencer fields can be merged into the core bus.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    READ,
    DRAIN,
    EMIT,
    FIN
  } state_t;

  localparam int ACC_BIT      = 33;
  localparam int CEN_PMEM_BIT = 32;
  localparam int WEN_PMEM_BIT = 31;
  localparam int A_PMEM_MSB   = 30;
  localparam int A_PMEM_LSB   = 20;

  localparam int KIJ_SQRT_DEF  = 3;
  localparam int ONIJ_SQRT_DEF = 4;

  function automatic int len_sq(input int side);
    return side * side;
  endfunction

  // Counter width that stays legal for a count of one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LEN_KIJ  = len_sq(KIJ_SQRT_DEF);
  localparam int LEN_ONIJ = len_sq(ONIJ_SQRT_DEF);

  function automatic logic [ACC_BIT:0] merge_pmem_fields(
    input logic [ACC_BIT:0]               inst,
    input logic                           acc,
    input logic                           cen,
    input logic                           wen,
    input logic [A_PMEM_MSB-A_PMEM_LSB:0] addr
  );
    logic [ACC_BIT:0] r;
    r                        = inst;
    r[ACC_BIT]               = acc;
    r[CEN_PMEM_BIT]          = cen;
    r[WEN_PMEM_BIT]          = wen;
    r[A_PMEM_MSB:A_PMEM_LSB] = addr;
    return r;
  endfunction

endpackage

// File: rtl/psum_acc_seq_if.sv
// Control, pmem and pixel-handshake signals between the sequencer (master) and its environment.
interface psum_acc_seq_if #(
  parameter int AW = 11,
  parameter int IW = 4
);
  logic          start;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          CEN_pmem;
  logic          WEN_pmem;
  logic [AW-1:0] A_pmem;
  logic          acc;
  logic          sfp_reset;
  logic          out_valid;
  logic [IW-1:0] out_idx;

  modport master (
    input  start, out_ready,
    output busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, sfp_reset, out_valid, out_idx
  );

  modport slave (
    output start, out_ready,
    input  busy, done, CEN_pmem, WEN_pmem, A_pmem, acc, sfp_reset, out_valid, out_idx
  );
endinterface

// File: rtl/psum_acc_seq_addr_gen.sv
// Incremental pmem read-address generator: tracks pixel o (col and row base) and kernel position ki/kj.
// Adds only constants per step, so the read path contains no multipliers.
module psum_acc_seq_addr_gen
  import core_pkg::*;
#(
  parameter int AW         = 11,
  parameter int KIJ_SQRT   = 3,
  parameter int NIJ_SQRT   = 6,
  parameter int ONIJ_SQRT  = 4,
  parameter int KIJ_STRIDE = 37,
  parameter int ADDR_BASE  = 0,
  parameter int OW         = cw(len_sq(ONIJ_SQRT))
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          step,
  input  logic          next,
  output logic [AW-1:0] addr,
  output logic [OW-1:0] o,
  output logic          j_last,
  output logic          o_last
);

  localparam int KW = cw(KIJ_SQRT);
  localparam int CW = cw(ONIJ_SQRT);

  localparam logic [AW-1:0] STEP_KJ  = AW'(KIJ_STRIDE + 1);
  localparam logic [AW-1:0] STEP_KI  = AW'(KIJ_STRIDE + 1 + NIJ_SQRT - KIJ_SQRT);
  localparam logic [AW-1:0] ROW_WRAP = AW'(NIJ_SQRT - ONIJ_SQRT + 1);
  localparam logic [AW-1:0] BASE     = AW'(ADDR_BASE);
  localparam logic [KW-1:0] K_MAX    = KW'(KIJ_SQRT - 1);
  localparam logic [CW-1:0] C_MAX    = CW'(ONIJ_SQRT - 1);
  localparam logic [OW-1:0] O_MAX    = OW'(len_sq(ONIJ_SQRT) - 1);

  logic [KW-1:0] ki;
  logic [KW-1:0] kj;
  logic [CW-1:0] ocol;
  logic [AW-1:0] pix_base;

  // pix_base = orow*NIJ_SQRT + ocol, maintained alongside o.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ki       <= '0;
      kj       <= '0;
      ocol     <= '0;
      o        <= '0;
      pix_base <= '0;
      addr     <= '0;
    end else begin
      if (load) begin
        ki   <= '0;
        kj   <= '0;
        addr <= BASE + pix_base;
      end else if (step) begin
        if (kj == K_MAX) begin
          kj   <= '0;
          ki   <= ki + 1'b1;
          addr <= addr + STEP_KI;
        end else begin
          kj   <= kj + 1'b1;
          addr <= addr + STEP_KJ;
        end
      end

      if (next) begin
        o <= o + 1'b1;
        if (ocol == C_MAX) begin
          ocol     <= '0;
          pix_base <= pix_base + ROW_WRAP;
        end else begin
          ocol     <= ocol + 1'b1;
          pix_base <= pix_base + 1'b1;
        end
      end
    end
  end

  assign j_last = (ki == K_MAX) && (kj == K_MAX);
  assign o_last = (o == O_MAX);

endmodule

// File: rtl/psum_acc_seq.sv
// Accumulation sequencer: per output pixel clears the SFP, reads LEN_KIJ psums, accumulates, then
// holds the pixel on out_valid until out_ready; 12 cycles per pixel with out_ready high.
module psum_acc_seq
  import core_pkg::*;
#(
  parameter int AW         = 11,
  parameter int KIJ_SQRT   = 3,
  parameter int NIJ_SQRT   = 6,
  parameter int ONIJ_SQRT  = 4,
  parameter int KIJ_STRIDE = 37,
  parameter int ADDR_BASE  = 0
) (
  input logic            clk,
  input logic            reset,
  psum_acc_seq_if.master bus
);

  localparam int OW = cw(len_sq(ONIJ_SQRT));

  state_t state;
  state_t nxt;

  logic [AW-1:0] addr;
  logic [OW-1:0] o;
  logic          j_last;
  logic          o_last;
  logic          gen_clr;
  logic          gen_load;
  logic          gen_step;
  logic          gen_next;

  logic busy_d, done_d, cen_d, acc_d, sfp_d, valid_d;
  logic busy_q, done_q, cen_q, acc_q, sfp_q, valid_q;

  // Address and pixel counters are zeroed whenever the sequencer is (about to be) idle.
  assign gen_clr  = (state == IDLE) || (state == FIN);
  assign gen_load = (state == CLR);
  assign gen_step = (state == READ) && !j_last;
  assign gen_next = (state == EMIT) && bus.out_ready && !o_last;

  psum_acc_seq_addr_gen #(
    .AW        (AW),
    .KIJ_SQRT  (KIJ_SQRT),
    .NIJ_SQRT  (NIJ_SQRT),
    .ONIJ_SQRT (ONIJ_SQRT),
    .KIJ_STRIDE(KIJ_STRIDE),
    .ADDR_BASE (ADDR_BASE),
    .OW        (OW)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (gen_clr),
    .load  (gen_load),
    .step  (gen_step),
    .next  (gen_next),
    .addr  (addr),
    .o     (o),
    .j_last(j_last),
    .o_last(o_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b1;
      acc_q   <= 1'b0;
      sfp_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state   <= nxt;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cen_q   <= cen_d;
      acc_q   <= acc_d;
      sfp_q   <= sfp_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (bus.start) nxt = CLR;
      CLR:     nxt = READ;
      READ:    if (j_last) nxt = DRAIN;
      DRAIN:   nxt = EMIT;
      EMIT:    if (bus.out_ready) nxt = o_last ? FIN : CLR;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Decoded from the next state so every control output is a flop aligned with its state.
  always_comb begin
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cen_d   = 1'b1;
    acc_d   = 1'b0;
    sfp_d   = 1'b0;
    valid_d = 1'b0;
    unique case (nxt)
      CLR: begin
        busy_d = 1'b1;
        sfp_d  = 1'b1;
      end
      READ: begin
        busy_d = 1'b1;
        cen_d  = 1'b0;
        acc_d  = (state == READ);
      end
      DRAIN: begin
        busy_d = 1'b1;
        acc_d  = 1'b1;
      end
      EMIT: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
      end
      FIN:     done_d = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.CEN_pmem  = cen_q;
  assign bus.WEN_pmem  = 1'b1;
  assign bus.A_pmem    = addr;
  assign bus.acc       = acc_q;
  assign bus.sfp_reset = sfp_q;
  assign bus.out_valid = valid_q;
  assign bus.out_idx   = o;

endmodule

// File: tb/tb_psum_acc_seq.sv
// Bench for psum_acc_seq: cycle-indexed trace checked against a vector table, plus an address/index
// scoreboard fed from an independent closed-form model.
module tb_psum_acc_seq;
  import core_pkg::*;

  localparam int MAXC = 260;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_acc_seq_if #(.AW(11), .IW(4)) bus ();

  psum_acc_seq dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cen;
    logic        wen;
    logic [10:0] a;
    logic        acc;
    logic        sfp;
    logic        ov;
    logic [3:0]  idx;
  } snap_t;

  typedef struct {
    int    c;
    snap_t exp;
  } vec_t;

  int    n_chk = 0;
  int    n_fail = 0;
  int    ov_cnt;
  int    done_cnt;
  int    addr_q[$];
  int    idx_q[$];
  snap_t trace[0:299];
  vec_t  vecs[21];
  snap_t idle_s;

  function automatic snap_t mk(input bit busy, input bit done, input bit cen, input int a,
                               input bit acc, input bit sfp, input bit ov, input int idx);
    snap_t s;
    s.busy = busy; s.done = done; s.cen = cen; s.wen = 1'b1; s.a = 11'(a);
    s.acc = acc; s.sfp = sfp; s.ov = ov; s.idx = 4'(idx);
    return s;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.busy = bus.busy; s.done = bus.done; s.cen = bus.CEN_pmem; s.wen = bus.WEN_pmem;
    s.a = bus.A_pmem; s.acc = bus.acc; s.sfp = bus.sfp_reset; s.ov = bus.out_valid; s.idx = bus.out_idx;
    return s;
  endfunction

  task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b cen=%b wen=%b a=%0d acc=%b sfp=%b ov=%b idx=%0d, expected busy=%b done=%b cen=%b wen=%b a=%0d acc=%b sfp=%b ov=%b idx=%0d",
               name, act.busy, act.done, act.cen, act.wen, act.a, act.acc, act.sfp, act.ov, act.idx,
               exp.busy, exp.done, exp.cen, exp.wen, exp.a, exp.acc, exp.sfp, exp.ov, exp.idx);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pass();
    for (int o = 0; o < 16; o++) begin
      idx_q.push_back(o);
      for (int j = 0; j < 9; j++)
        addr_q.push_back(j * 37 + (o / 4 + j / 3) * 6 + (o % 4 + j % 3));
    end
  endtask

  task automatic score(input snap_t s);
    int e;
    chk_int("wen_high", int'(s.wen), 1);
    if (s.cen === 1'b0) begin
      if (addr_q.size() == 0) chk_int("addr_q_underflow", 1, 0);
      else begin
        e = addr_q.pop_front();
        chk_int("sb_addr", int'(s.a), e);
      end
    end
    if (s.ov === 1'b1 && bus.out_ready === 1'b1) begin
      ov_cnt++;
      if (idx_q.size() == 0) chk_int("idx_q_underflow", 1, 0);
      else begin
        e = idx_q.pop_front();
        chk_int("sb_idx", int'(s.idx), e);
      end
    end
    if (s.done === 1'b1) done_cnt++;
  endtask

  // Each iteration samples cycle c (#1 after its opening edge) and drives inputs for that same cycle.
  task automatic run_pass(input int stall_c, input int abort_c, input int busy_start_c, output int done_c);
    int last_c;
    push_pass();
    ov_cnt = 0; done_cnt = 0; done_c = -1; last_c = MAXC;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= last_c; c++) begin
      trace[c] = snap();
      if (trace[c].done === 1'b1 && done_c < 0) begin
        done_c = c;
        last_c = c + 1;
      end
      bus.start     = (c == busy_start_c);
      bus.out_ready = !(stall_c > 0 && c >= stall_c && c < stall_c + 5);
      if (abort_c > 0 && c == abort_c) reset = 1'b1;
      if (abort_c > 0 && c == abort_c + 1) begin
        reset  = 1'b0;
        last_c = abort_c + 4;
      end
      if (reset === 1'b0) score(trace[c]);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    idle_s = mk(0, 0, 1, 0, 0, 0, 0, 0);
    vecs[0]  = '{1,   mk(1, 0, 1, 0,   0, 1, 0, 0)};
    vecs[1]  = '{2,   mk(1, 0, 0, 0,   0, 0, 0, 0)};
    vecs[2]  = '{3,   mk(1, 0, 0, 38,  1, 0, 0, 0)};
    vecs[3]  = '{4,   mk(1, 0, 0, 76,  1, 0, 0, 0)};
    vecs[4]  = '{5,   mk(1, 0, 0, 117, 1, 0, 0, 0)};
    vecs[5]  = '{6,   mk(1, 0, 0, 155, 1, 0, 0, 0)};
    vecs[6]  = '{7,   mk(1, 0, 0, 193, 1, 0, 0, 0)};
    vecs[7]  = '{8,   mk(1, 0, 0, 234, 1, 0, 0, 0)};
    vecs[8]  = '{9,   mk(1, 0, 0, 272, 1, 0, 0, 0)};
    vecs[9]  = '{10,  mk(1, 0, 0, 310, 1, 0, 0, 0)};
    vecs[10] = '{11,  mk(1, 0, 1, 310, 1, 0, 0, 0)};
    vecs[11] = '{12,  mk(1, 0, 1, 310, 0, 0, 1, 0)};
    vecs[12] = '{13,  mk(1, 0, 1, 310, 0, 1, 0, 1)};
    vecs[13] = '{14,  mk(1, 0, 0, 1,   0, 0, 0, 1)};
    vecs[14] = '{62,  mk(1, 0, 0, 7,   0, 0, 0, 5)};
    vecs[15] = '{70,  mk(1, 0, 0, 317, 1, 0, 0, 5)};
    vecs[16] = '{182, mk(1, 0, 0, 21,  0, 0, 0, 15)};
    vecs[17] = '{190, mk(1, 0, 0, 331, 1, 0, 0, 15)};
    vecs[18] = '{192, mk(1, 0, 1, 331, 0, 0, 1, 15)};
    vecs[19] = '{193, mk(0, 1, 1, 331, 0, 0, 0, 15)};
    vecs[20] = '{194, idle_s};

    reset = 1'b1; bus.start = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_snap("reset_idle", snap(), idle_s);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; reset = 1'b0;
    chk_snap("start_with_reset", snap(), idle_s);
    @(posedge clk); #1;
    chk_snap("idle_after_reset", snap(), idle_s);

    // Full pass, out_ready tied high.
    run_pass(0, 0, 0, dc);
    for (int i = 0; i < 21; i++)
      chk_snap($sformatf("pass_c%0d", vecs[i].c), trace[vecs[i].c], vecs[i].exp);
    chk_int("pass_done_cycle", dc, 193);
    chk_int("pass_valid_count", ov_cnt, 16);
    chk_int("pass_done_count", done_cnt, 1);
    chk_int("pass_addr_left", addr_q.size(), 0);
    chk_int("pass_idx_left", idx_q.size(), 0);

    // Stall at pixel 3 for 5 cycles.
    run_pass(48, 0, 0, dc);
    for (int c = 48; c <= 53; c++)
      chk_snap($sformatf("stall_c%0d", c), trace[c], mk(1, 0, 1, 313, 0, 0, 1, 3));
    chk_snap("stall_next_clr", trace[54], mk(1, 0, 1, 313, 0, 1, 0, 4));
    chk_int("stall_done_cycle", dc, 198);
    chk_int("stall_valid_count", ov_cnt, 16);
    chk_int("stall_done_count", done_cnt, 1);
    chk_int("stall_addr_left", addr_q.size(), 0);

    // Reset during READ of pixel 7, j=4.
    run_pass(0, 90, 0, dc);
    chk_snap("abort_read_j4", trace[90], mk(1, 0, 0, 164, 1, 0, 0, 7));
    chk_snap("abort_idle", trace[91], idle_s);
    chk_snap("abort_still_idle", trace[94], idle_s);
    chk_int("abort_no_done", done_cnt, 0);
    chk_int("abort_done_cycle", dc, -1);
    addr_q.delete();
    idx_q.delete();

    // Restart from pixel 0, with a start pulse while busy at pixel 2.
    run_pass(0, 0, 26, dc);
    chk_snap("restart_clr", trace[1], mk(1, 0, 1, 0, 0, 1, 0, 0));
    chk_snap("restart_addr0", trace[2], mk(1, 0, 0, 0, 0, 0, 0, 0));
    chk_int("busy_start_done_cycle", dc, 193);
    chk_int("busy_start_done_count", done_cnt, 1);
    chk_int("busy_start_valid_count", ov_cnt, 16);
    chk_snap("busy_start_idle", trace[194], idle_s);
    chk_int("busy_start_addr_left", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_acc_seq.md
Name: psum_acc_seq

Overview:
- Accumulation-phase sequencer for the weight-stationary core. It sits directly upstream of the core instruction bus and drives the pmem and accumulate fields: inst[33] acc, inst[32] CEN_pmem, inst[31] WEN_pmem, inst[30:20] A_pmem.
- For each output pixel it clears the SFP, then reads the LEN_KIJ partial sums for that pixel from pmem in order and accumulates them. It then presents the finished pixel to the downstream checker/writer with a valid/ready handshake.
- It replaces the hand-sequenced accumulation loop, so the whole accumulate phase runs from a single start pulse.

Parameters:
- AW, 11, pmem address width.
- KIJ_SQRT, 3, kernel side length; LEN_KIJ = KIJ_SQRT*KIJ_SQRT.
- NIJ_SQRT, 6, input image side length.
- ONIJ_SQRT, 4, output image side length; LEN_ONIJ = ONIJ_SQRT*ONIJ_SQRT.
- KIJ_STRIDE, 37, pmem words per kij block (len_nij plus one OFIFO-flush word).
- ADDR_BASE, 0, pmem address of the kij=0, nij=0 entry.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a full accumulation pass; ignored while busy.
- out_ready  in  1  downstream is ready to accept the current pixel.
- busy  out  1  high from the cycle after an accepted start until the cycle done is high.
- done  out  1  one-cycle pulse after the last pixel handshake.
- CEN_pmem  out  1  pmem chip enable, active-low.
- WEN_pmem  out  1  pmem write enable, active-low; always 1 in this block.
- A_pmem  out  AW  pmem read address.
- acc  out  1  SFP accumulate strobe.
- sfp_reset  out  1  one-cycle SFP clear.
- out_valid  out  1  the SFP holds the finished pixel.
- out_idx  out  $clog2(LEN_ONIJ)  index of the current pixel o.

Behaviour:
- All outputs are registered.
- Reset and idle values: CEN_pmem=1, WEN_pmem=1, A_pmem=0, acc=0, sfp_reset=0, out_valid=0, out_idx=0, busy=0, done=0; state IDLE.
- States: IDLE, CLR, READ, DRAIN, EMIT, FIN.
- IDLE: on start, set o=0 and go to CLR.
- CLR (1 cycle): sfp_reset=1, CEN_pmem=1, acc=0. Set j=0 and go to READ.
- READ (LEN_KIJ cycles, j = 0..LEN_KIJ-1):
  - CEN_pmem=0, WEN_pmem=1.
  - A_pmem = ADDR_BASE + j*KIJ_STRIDE + (orow+ki)*NIJ_SQRT + (ocol+kj), where ki=j/KIJ_SQRT, kj=j%KIJ_SQRT, orow=o/ONIJ_SQRT, ocol=o%ONIJ_SQRT.
  - acc=1 for j>=1, because pmem data lags the address by one cycle.
  - After j=LEN_KIJ-1, go to DRAIN.
- DRAIN (1 cycle): CEN_pmem=1, A_pmem holds its last value, acc=1 to accumulate the final read.
- EMIT: acc=0, out_valid=1, out_idx=o.
  - Stay in EMIT while out_ready=0; outputs are held stable.
  - On out_ready=1: if o=LEN_ONIJ-1 go to FIN, else increment o and go to CLR.
- FIN (1 cycle): done=1, busy=0, then IDLE.
- Timing:
  - start to first sfp_reset: 1 cycle.
  - Per pixel with out_ready tied high: 1+LEN_KIJ+1+1 = 12 cycles.
  - Full pass: 16*12+1 = 193 cycles after CLR entry.
- Address arithmetic:
  - Computed incrementally: kj steps +1; at a ki wrap add NIJ_SQRT-KIJ_SQRT; always add KIJ_STRIDE per j.
  - No multipliers in the READ path.
  - Results are truncated to AW bits; with the defaults the maximum is 331, so no wrap occurs.
- Edge cases:
  - start while busy is ignored.
  - start in the same cycle as reset: reset wins.
  - Reset in any state returns to idle values on the next edge. A partially accumulated pixel is discarded and no done pulse is issued.
  - out_ready high outside EMIT has no effect.

Decomposition:
- Shared package core_pkg holds:
  - the state enum;
  - LEN_KIJ and LEN_ONIJ derivations;
  - the inst bit-position constants ACC_BIT=33, CEN_PMEM_BIT=32, WEN_PMEM_BIT=31, A_PMEM_MSB=30, A_PMEM_LSB=20.
- One natural sub-module: psum_addr_gen, the incremental A_pmem generator. It tracks o, j, ki, kj, load and step controls, and flags the last j.

Test Plan:
- Reset, then start, out_ready=1 → pixel 0: sfp_reset one cycle; A_pmem = 0,38,76,117,155,193,234,272,310 in consecutive cycles with CEN_pmem=0; acc high for 9 cycles starting 1 cycle after address 0; out_valid with out_idx=0 at cycle 12.
- Same pass, pixel 5 (orow=1, ocol=1) → A_pmem sequence starts at 7 and ends at 317; pixel 15 sequence is 21..331.
- Full pass with out_ready=1 → exactly 16 out_valid pulses, idx 0..15; done pulse once; busy falls with done; WEN_pmem=1 throughout.
- Hold out_ready=0 for 5 cycles at pixel 3 → out_valid, out_idx=3 and A_pmem stable; CEN_pmem=1 and acc=0 during the stall; next CLR begins 1 cycle after out_ready rises.
- Assert reset during READ of pixel 7 at j=4 → next cycle all outputs at idle values; no done; a subsequent start restarts from pixel 0 with address 0.
- Pulse start while busy at pixel 2 → no effect; pass completes in 193 cycles with a single done.
